// File: rtl/sseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : sseg_capture
// Brief    : Recovers a 4-digit hex frame from a multiplexed active-low
//            7-segment scan. Optional decimal-point capture: SSEG_CAPTURE_DP_EN.
// Revision : 1.0  initial release
// ============================================================================
module sseg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  an_i,
  input  logic [6:0]  sseg_i,
`ifdef SSEG_CAPTURE_DP_EN
  input  logic        dp_i,
  output logic [3:0]  dp_o,
`endif
  output logic [15:0] hex_o,
  output logic        frame_valid_o,
  output logic        digit_err_o
);

`ifdef SSEG_CAPTURE_DP_EN
  localparam int c_SW = 12;
`else
  localparam int c_SW = 11;
`endif
  localparam logic [7:0] c_ACCEPT_CNT = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  logic [c_SW-1:0] r_smp;
  logic [c_SW-1:0] r_prev;
  logic [7:0]      r_cnt;
  state_t          r_state;
  logic [3:0]      r_seen;
  logic [15:0]     r_slots;
  logic [15:0]     r_hex;
  logic            r_fv;
  logic            r_err;

  logic [c_SW-1:0] w_smp_in;
  logic [3:0]      w_an;
  logic [6:0]      w_seg;
  logic            w_acc;
  logic            w_sel_ok;
  logic            w_dec_ok;
  logic            w_take;
  logic [1:0]      w_idx;
  logic [3:0]      w_val;
  logic [3:0]      w_bit;

`ifdef SSEG_CAPTURE_DP_EN
  logic [3:0] r_dp_slots;
  logic [3:0] r_dp;
  assign w_smp_in = {dp_i, an_i, sseg_i};
  assign dp_o     = r_dp;
`else
  assign w_smp_in = {an_i, sseg_i};
`endif

  // Decisions are made on the older sample, which is the one the counter has vouched for
  assign w_an   = r_prev[10:7];
  assign w_seg  = r_prev[6:0];
  assign w_acc  = (r_cnt == c_ACCEPT_CNT);
  assign w_take = w_acc & w_sel_ok;
  assign w_bit  = 4'b0001 << w_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_smp  <= '1;
      r_prev <= '1;
      r_cnt  <= 8'd0;
    end else begin
      r_smp  <= w_smp_in;
      r_prev <= r_smp;
      if (r_smp != r_prev)
        r_cnt <= 8'd0;
      else if (r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_sel_ok = 1'b1;
    w_idx    = 2'd0;
    case (w_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_dec_ok = 1'b1;
    w_val    = 4'h0;
    case (w_seg)
      7'b1000000: w_val = 4'h0;
      7'b1111001: w_val = 4'h1;
      7'b0100100: w_val = 4'h2;
      7'b0110000: w_val = 4'h3;
      7'b0011001: w_val = 4'h4;
      7'b0010010: w_val = 4'h5;
      7'b0000010: w_val = 4'h6;
      7'b1111000: w_val = 4'h7;
      7'b0000000: w_val = 4'h8;
      7'b0010000: w_val = 4'h9;
      7'b0001000: w_val = 4'hA;
      7'b0000011: w_val = 4'hB;
      7'b1000110: w_val = 4'hC;
      7'b0100001: w_val = 4'hD;
      7'b0000110: w_val = 4'hE;
      7'b0001110: w_val = 4'hF;
      default:    w_dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_SYNC;
      r_seen  <= 4'b0000;
      r_slots <= 16'h0000;
      r_hex   <= 16'h0000;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
      r_dp_slots <= 4'b0000;
      r_dp       <= 4'b0000;
`endif
    end else begin
      r_fv <= 1'b0;
      if (w_take && !w_dec_ok && r_state != S_EMIT)
        r_err <= 1'b1;
      case (r_state)
        S_SYNC: begin
          if (w_take && w_dec_ok && w_idx == 2'd0) begin
            r_slots[3:0] <= w_val;
`ifdef SSEG_CAPTURE_DP_EN
            r_dp_slots[0] <= ~r_prev[11];
`endif
            r_seen  <= 4'b0001;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_take) begin
            if (w_dec_ok) begin
              r_slots[{w_idx, 2'b00} +: 4] <= w_val;
`ifdef SSEG_CAPTURE_DP_EN
              r_dp_slots[w_idx] <= ~r_prev[11];
`endif
              r_seen <= r_seen | w_bit;
              if ((r_seen | w_bit) == 4'b1111)
                r_state <= S_EMIT;
            end else begin
              r_seen  <= 4'b0000;
              r_state <= S_SYNC;
            end
          end
        end
        S_EMIT: begin
          r_hex   <= r_slots;
          r_fv    <= 1'b1;
          r_seen  <= 4'b0000;
          r_state <= S_SYNC;
`ifdef SSEG_CAPTURE_DP_EN
          r_dp    <= r_dp_slots;
`endif
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign hex_o         = r_hex;
  assign frame_valid_o = r_fv;
  assign digit_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_capture
// Brief    : Randomised and directed bench for sseg_capture with a dwell-based
//            reference model. Decimal-point checks under SSEG_CAPTURE_DP_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_sseg_capture;
  localparam int S = 4;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic        dpv = 1'b1;
  logic [15:0] hex;
  logic        fv;
  logic        err;
`ifdef SSEG_CAPTURE_DP_EN
  logic [3:0]  dp_o;
  logic [3:0]  last_dp = 4'h0;
`endif

  int checks   = 0;
  int failures = 0;
  int npulse   = 0;

  sseg_capture #(.STABLE_CYCLES(S)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .an_i          (an),
    .sseg_i        (seg),
`ifdef SSEG_CAPTURE_DP_EN
    .dp_i          (dpv),
    .dp_o          (dp_o),
`endif
    .hex_o         (hex),
    .frame_valid_o (fv),
    .digit_err_o   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int k = 0; k < 16; k++)
      if (SEG[k] == p) return k;
    return -1;
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    for (int k = 0; k < 4; k++)
      if (a == ~(4'b0001 << k)) return k;
    return -1;
  endfunction

  // Reference: a digit counts once its sample has been seen S edges in a row;
  // it takes effect two edges after its last sample, and a full frame one edge later.
  logic        m_ready = 1'b0;
  logic [15:0] m_hex;
  logic        m_fv, m_err, m_collect, m_emit;
  logic [3:0]  m_seen, m_dp, m_dpslots;
  logic [3:0]  m_slots [4];
  logic [11:0] s1, s2, x;
  int          run1, run2, mk, mv;

  always @(posedge clk) begin
    x = {dpv, an, seg};
    if (rst) begin
      m_ready = 1'b1;
      m_hex = 16'h0; m_fv = 1'b0; m_err = 1'b0; m_collect = 1'b0; m_emit = 1'b0;
      m_seen = 4'h0; m_dp = 4'h0; m_dpslots = 4'h0;
      for (int k = 0; k < 4; k++) m_slots[k] = 4'h0;
      s1 = '1; s2 = '1; run1 = 2; run2 = 2;
    end else begin
      m_fv = 1'b0;
      mk = digit_of(s2[10:7]);
      if (m_emit) begin
        m_hex  = {m_slots[3], m_slots[2], m_slots[1], m_slots[0]};
        m_dp   = m_dpslots;
        m_fv   = 1'b1;
        m_emit = 1'b0;
      end else if (run2 == S && mk >= 0) begin
        mv = decode(s2[6:0]);
        if (mv < 0) begin
          m_err = 1'b1; m_collect = 1'b0; m_seen = 4'h0;
        end else if (m_collect || mk == 0) begin
          m_slots[mk]   = mv[3:0];
          m_dpslots[mk] = ~s2[11];
          m_seen        = m_seen | (4'b0001 << mk);
          m_collect     = 1'b1;
          if (m_seen == 4'hF) begin
            m_emit = 1'b1; m_collect = 1'b0; m_seen = 4'h0;
          end
        end
      end
      s2 = s1; run2 = run1;
      run1 = (x == s1) ? ((run1 < 1000) ? run1 + 1 : run1) : 1;
      s1 = x;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("frame_valid", {31'd0, fv}, {31'd0, m_fv});
      chk("hex", {16'd0, hex}, {16'd0, m_hex});
      chk("digit_err", {31'd0, err}, {31'd0, m_err});
`ifdef SSEG_CAPTURE_DP_EN
      chk("dp", {28'd0, dp_o}, {28'd0, m_dp});
`endif
    end
    if (fv === 1'b1) begin
      npulse++;
`ifdef SSEG_CAPTURE_DP_EN
      last_dp = dp_o;
`endif
    end
  end

  task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dpv = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    show(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic scan(input logic [15:0] h, input int hold);
    for (int k = 0; k < 4; k++)
      show(~(4'b0001 << k), SEG[h[4*k +: 4]], 1'b1, hold);
    idle(6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    int nk;
    logic [3:0] ra;
    logic [6:0] rs;
    do_reset();
    #1;
    chk("reset_hex", {16'd0, hex}, 32'h0);
    chk("reset_fv", {31'd0, fv}, 32'h0);
    chk("reset_err", {31'd0, err}, 32'h0);

    p0 = npulse;
    scan(16'h4321, 3);
    #1;
    chk("short_hold_pulses", npulse - p0, 32'd0);
    chk("short_hold_hex", {16'd0, hex}, 32'h0);

    p0 = npulse;
    scan(16'h1329, 4);
    #1;
    chk("scan1329_pulses", npulse - p0, 32'd1);
    chk("scan1329_hex", {16'd0, hex}, 32'h1329);
    chk("scan1329_model", {16'd0, m_hex}, 32'h1329);
    chk("scan1329_err", {31'd0, err}, 32'h0);

    p0 = npulse;
    show(4'b1011, 7'b0011001, 1'b1, 4);
    show(4'b0111, SEG[5], 1'b1, 4);
    idle(6);
    #1;
    chk("sync_ignore_pulses", npulse - p0, 32'd0);
    scan(16'h5678, 4);
    #1;
    chk("resync_pulses", npulse - p0, 32'd1);
    chk("resync_hex", {16'd0, hex}, 32'h5678);

    p0 = npulse;
    show(4'b1110, SEG[1], 1'b1, 4);
    show(4'b1101, SEG[2], 1'b1, 4);
    show(4'b1011, 7'h7F, 1'b1, 4);
    show(4'b0111, SEG[4], 1'b1, 4);
    idle(6);
    #1;
    chk("blank_err", {31'd0, err}, 32'h1);
    chk("blank_pulses", npulse - p0, 32'd0);
    chk("blank_hex_held", {16'd0, hex}, 32'h5678);
    scan(16'h1234, 4);
    #1;
    chk("after_err_hex", {16'd0, hex}, 32'h1234);
    chk("after_err_sticky", {31'd0, err}, 32'h1);

    p0 = npulse;
    show(4'b1110, SEG[7], 1'b1, 4);
    show(4'b1101, SEG[5], 1'b1, 4);
    show(4'b1011, SEG[3], 1'b1, 4);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_hex", {16'd0, hex}, 32'h0);
    chk("midreset_fv", {31'd0, fv}, 32'h0);
    chk("midreset_err", {31'd0, err}, 32'h0);
    idle(6);
    #1;
    chk("midreset_pulses", npulse - p0, 32'd0);
    scan(16'hABCD, 4);
    #1;
    chk("abcd_hex", {16'd0, hex}, 32'hABCD);
    chk("abcd_pulses", npulse - p0, 32'd1);

`ifdef SSEG_CAPTURE_DP_EN
    for (int k = 0; k < 4; k++)
      show(~(4'b0001 << k), SEG[k + 4], (k == 1) ? 1'b0 : 1'b1, 4);
    idle(6);
    #1;
    chk("dp_digit1", {28'd0, last_dp}, 32'h2);
    chk("dp_hex", {16'd0, hex}, 32'h7654);
`endif

    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      nk = 0;
      for (int step = 0; step < 60; step++) begin
        if ($urandom_range(0, 99) < 85) begin
          ra = ~(4'b0001 << nk);
          nk = (nk + 1) % 4;
        end else begin
          ra = 4'($urandom);
        end
        rs = ($urandom_range(0, 19) == 0) ? 7'($urandom) : SEG[$urandom_range(0, 15)];
        show(ra, rs, 1'($urandom), $urandom_range(3, 6));
      end
      idle(8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (legal range 2..255): consecutive identical registered samples of (an_i, sseg_i) required before a digit is accepted.
REQ-002 SHALL have port clk_i, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port an_i, input, 4 bits: active-low digit anodes; bit k low selects digit k, where digit 0 is the rightmost digit.
REQ-005 SHALL have port sseg_i, input, 7 bits: active-low segments; bit 6 is g and bit 0 is a.
REQ-006 SHALL have port hex_o, output, 16 bits: last complete captured frame; digit k occupies bits [4k+3:4k].
REQ-007 SHALL have port frame_valid_o, output, 1 bit: one-cycle pulse, asserted on the same edge that hex_o updates.
REQ-008 SHALL have port digit_err_o, output, 1 bit: sticky flag for an undecodable stable segment pattern.

Function
REQ-009 SHALL register an_i and sseg_i in one input stage; all further logic SHALL use only the registered copies.
REQ-010 Stability counter, 8 bits: SHALL load 0 when the registered pair differs from the previous registered pair, otherwise increment, saturating at 255.
REQ-011 A digit SHALL be accepted only on the cycle the counter equals STABLE_CYCLES-1, so acceptance happens once per dwell.
REQ-012 The registered an value SHALL be exactly one bit low for an acceptance; the values 4'b1111 and any pattern with two or more bits low SHALL never be accepted.
REQ-013 Decode table, active-low gfedcba, mapping hex value to pattern:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-014 Any other pattern, including blank 1111111, SHALL set digit_err_o on acceptance and SHALL NOT store the digit or set its seen bit.
REQ-015 FSM state SYNC: ignore all acceptances except digit 0 (an=1110); a valid digit 0 SHALL be stored, seen=0001, and the FSM SHALL move to COLLECT.
REQ-016 FSM state COLLECT: each valid acceptance SHALL store into slot k and set seen[k]; a repeated digit SHALL overwrite its slot.
- When seen becomes 4'b1111, the FSM SHALL go to EMIT.
REQ-017 FSM state EMIT, one cycle: hex_o SHALL load all four slots, frame_valid_o SHALL be 1, seen SHALL clear, and the next state SHALL be SYNC.
- Latency: frame_valid_o is asserted 2 clocks after the cycle the fourth digit is accepted.
REQ-018 An invalid pattern in COLLECT SHALL abort the frame: seen cleared, return to SYNC.
REQ-019 hex_o SHALL hold its value between EMIT cycles; a partial frame SHALL never be visible on hex_o.

Reset
REQ-020 On rst_i=1 at an edge, the following SHALL reset:
- hex_o=16'h0000, frame_valid_o=0, digit_err_o=0
- state=SYNC, seen=0, counter=0, digit slots=0
- input registers: an=4'b1111, sseg=7'b1111111
REQ-021 Reset mid-frame SHALL discard the partial frame and SHALL NOT produce a frame_valid_o pulse.
REQ-022 digit_err_o SHALL clear only on reset.

Configuration
REQ-023 With macro SSEG_CAPTURE_DP_EN defined:
- input dp_i (1 bit, active-low decimal point) SHALL be registered with sseg_i and included in the stability comparison.
- output dp_o (4 bits, active-high) SHALL load with hex_o in EMIT, bit k being digit k's point.
- dp_o SHALL reset to 0.
REQ-024 Without SSEG_CAPTURE_DP_EN, dp_i and dp_o SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-025 Scan 1110/0010000, 1101/0100100, 1011/0110000, 0111/1111001 for 4 cycles each (STABLE_CYCLES=4) -> one frame_valid_o pulse, hex_o=16'h1329, digit_err_o=0.
REQ-026 Start the scan at an=1011 holding 0011001 -> no acceptance in SYNC; a frame is emitted only after a full sequence that begins at digit 0.
REQ-027 Hold each digit for only 3 cycles -> no acceptance, frame_valid_o never asserts, hex_o stays 16'h0000.
REQ-028 Digit 2 shows 1111111 mid-frame -> digit_err_o=1 and stays set, no pulse; the next clean scan of 1234 gives hex_o=16'h1234.
REQ-029 Assert rst_i after three digits are accepted -> all outputs return to reset values and no pulse is produced; then a clean scan of ABCD gives hex_o=16'hABCD.
REQ-030 With SSEG_CAPTURE_DP_EN, hold dp_i=0 on digit 1 only -> dp_o=4'b0010 together with frame_valid_o.
